// File: rtl/hasti_slave_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : hasti_slave_mux_rr_if
// Brief    : Bus bundle for the N-port HASTI slave-side mux: upstream ins_*
//            vectors (port i at [i*W +: W]) and the single downstream out_* port.
// Revision : 1.0 - initial release
// ============================================================================
interface hasti_slave_mux_rr_if #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [N_PORTS*ADDR_W-1:0] ins_haddr;
    logic [N_PORTS-1:0]        ins_hwrite;
    logic [N_PORTS*3-1:0]      ins_hsize;
    logic [N_PORTS*3-1:0]      ins_hburst;
    logic [N_PORTS*4-1:0]      ins_hprot;
    logic [N_PORTS*2-1:0]      ins_htrans;
    logic [N_PORTS-1:0]        ins_hmastlock;
    logic [N_PORTS*DATA_W-1:0] ins_hwdata;
    logic [N_PORTS-1:0]        ins_hsel;
    logic [N_PORTS-1:0]        ins_hreadyin;
    logic [N_PORTS*DATA_W-1:0] ins_hrdata;
    logic [N_PORTS-1:0]        ins_hreadyout;
    logic [N_PORTS-1:0]        ins_hresp;

    logic [ADDR_W-1:0]         out_haddr;
    logic                      out_hwrite;
    logic [2:0]                out_hsize;
    logic [2:0]                out_hburst;
    logic [3:0]                out_hprot;
    logic [1:0]                out_htrans;
    logic                      out_hmastlock;
    logic [DATA_W-1:0]         out_hwdata;
    logic                      out_hsel;
    logic                      out_hreadyin;
    logic [DATA_W-1:0]         out_hrdata;
    logic                      out_hreadyout;
    logic                      out_hresp;

    // The mux itself: slave to the upstream masters, driver of the downstream slave.
    modport slave (
        input  ins_haddr, ins_hwrite, ins_hsize, ins_hburst, ins_hprot, ins_htrans,
        input  ins_hmastlock, ins_hwdata, ins_hsel, ins_hreadyin,
        output ins_hrdata, ins_hreadyout, ins_hresp,
        output out_haddr, out_hwrite, out_hsize, out_hburst, out_hprot, out_htrans,
        output out_hmastlock, out_hwdata, out_hsel, out_hreadyin,
        input  out_hrdata, out_hreadyout, out_hresp
    );

    // The surrounding environment: upstream masters plus the downstream slave.
    modport master (
        output ins_haddr, ins_hwrite, ins_hsize, ins_hburst, ins_hprot, ins_htrans,
        output ins_hmastlock, ins_hwdata, ins_hsel, ins_hreadyin,
        input  ins_hrdata, ins_hreadyout, ins_hresp,
        input  out_haddr, out_hwrite, out_hsize, out_hburst, out_hprot, out_htrans,
        input  out_hmastlock, out_hwdata, out_hsel, out_hreadyin,
        output out_hrdata, out_hreadyout, out_hresp
    );
endinterface
`default_nettype wire

// File: rtl/hasti_slave_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : hasti_slave_mux_rr
// Brief    : N-port AHB-Lite slave-side mux, round-robin arbitration with
//            per-port capture of stalled address phases. Define
//            HASTI_MUX_LOCK_EN to honour hmastlock in arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module hasti_slave_mux_rr #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    hasti_slave_mux_rr_if.slave  bus
);
    localparam int c_IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic                 w_ready;
    logic [N_PORTS-1:0]   w_live;
    logic [N_PORTS-1:0]   w_req;
    logic [N_PORTS-1:0]   w_req_arb;
    logic [N_PORTS-1:0]   w_addr_gnt;
    logic                 w_arb_found;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic [c_IDX_W-1:0]   w_scan_idx;
    logic                 w_gnt_valid;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic                 w_rr_freeze;

    logic [N_PORTS-1:0]   r_pend;
    logic [N_PORTS-1:0]   r_data_gnt;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic                 r_hold_valid;
    logic [c_IDX_W-1:0]   r_hold_idx;

    logic [ADDR_W-1:0]    r_haddr     [N_PORTS];
    logic                 r_hwrite    [N_PORTS];
    logic [2:0]           r_hsize     [N_PORTS];
    logic [2:0]           r_hburst    [N_PORTS];
    logic [3:0]           r_hprot     [N_PORTS];
    logic [1:0]           r_htrans    [N_PORTS];
    logic                 r_hmastlock [N_PORTS];

    assign w_ready          = bus.out_hreadyout;
    assign bus.out_hreadyin = bus.out_hreadyout;
    assign w_live           = bus.ins_hsel & bus.ins_hreadyin;
    assign w_req            = w_live | r_pend;

`ifdef HASTI_MUX_LOCK_EN
    logic                 r_lock_valid;
    logic [c_IDX_W-1:0]   r_lock_owner;
    logic [N_PORTS-1:0]   w_owner_mask;

    always_comb begin
        w_owner_mask               = '0;
        w_owner_mask[r_lock_owner] = 1'b1;
    end

    assign w_req_arb   = r_lock_valid ? (w_req & w_owner_mask) : w_req;
    assign w_rr_freeze = r_lock_valid;

    // An accepted transfer re-arms or releases the lock from its own hmastlock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= '0;
        end else if (r_lock_valid && !w_req[r_lock_owner]) begin
            r_lock_valid <= 1'b0;
        end else if (w_ready && w_gnt_valid) begin
            r_lock_valid <= bus.out_hmastlock;
            r_lock_owner <= w_gnt_idx;
        end
    end
`else
    assign w_req_arb   = w_req;
    assign w_rr_freeze = 1'b0;
`endif

    // Round-robin scan starting just after the last granted port.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_scan_idx = c_IDX_W'((int'(r_rr_ptr) + k) % N_PORTS);
            if (!w_arb_found && w_req_arb[w_scan_idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_scan_idx;
            end
        end
    end

    // A stalled downstream address phase keeps its owner until accepted.
    assign w_gnt_valid = r_hold_valid | w_arb_found;
    assign w_gnt_idx   = r_hold_valid ? r_hold_idx : w_arb_idx;

    always_comb begin
        w_addr_gnt = '0;
        if (w_gnt_valid) begin
            w_addr_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        bus.out_haddr     = '0;
        bus.out_hwrite    = 1'b0;
        bus.out_hsize     = '0;
        bus.out_hburst    = '0;
        bus.out_hprot     = '0;
        bus.out_htrans    = '0;
        bus.out_hmastlock = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (w_addr_gnt[i]) begin
                if (r_pend[i]) begin
                    bus.out_haddr     = r_haddr[i];
                    bus.out_hwrite    = r_hwrite[i];
                    bus.out_hsize     = r_hsize[i];
                    bus.out_hburst    = r_hburst[i];
                    bus.out_hprot     = r_hprot[i];
                    bus.out_htrans    = r_htrans[i];
                    bus.out_hmastlock = r_hmastlock[i];
                end else begin
                    bus.out_haddr     = bus.ins_haddr[i*ADDR_W +: ADDR_W];
                    bus.out_hwrite    = bus.ins_hwrite[i];
                    bus.out_hsize     = bus.ins_hsize[i*3 +: 3];
                    bus.out_hburst    = bus.ins_hburst[i*3 +: 3];
                    bus.out_hprot     = bus.ins_hprot[i*4 +: 4];
                    bus.out_htrans    = bus.ins_htrans[i*2 +: 2];
                    bus.out_hmastlock = bus.ins_hmastlock[i];
                end
            end
        end
    end
    assign bus.out_hsel = |w_addr_gnt;

    always_comb begin
        bus.out_hwdata    = '0;
        bus.ins_hrdata    = '0;
        bus.ins_hresp     = '0;
        bus.ins_hreadyout = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.out_hwdata = bus.out_hwdata
                           | (bus.ins_hwdata[i*DATA_W +: DATA_W] & {DATA_W{r_data_gnt[i]}});
            bus.ins_hrdata[i*DATA_W +: DATA_W] = r_data_gnt[i] ? bus.out_hrdata : '0;
            bus.ins_hresp[i]     = r_data_gnt[i] & bus.out_hresp;
            // A captured port stays stalled until its own data phase begins.
            bus.ins_hreadyout[i] = w_ready & (~r_pend[i] | r_data_gnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend       <= '0;
            r_data_gnt   <= '0;
            r_rr_ptr     <= c_IDX_W'(N_PORTS - 1);
            r_hold_valid <= 1'b0;
            r_hold_idx   <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                r_haddr[i]     <= '0;
                r_hwrite[i]    <= 1'b0;
                r_hsize[i]     <= '0;
                r_hburst[i]    <= '0;
                r_hprot[i]     <= '0;
                r_htrans[i]    <= '0;
                r_hmastlock[i] <= 1'b0;
            end
        end else begin
            r_hold_valid <= !w_ready && w_gnt_valid;
            r_hold_idx   <= w_gnt_idx;
            if (w_ready) begin
                r_data_gnt <= w_addr_gnt;
            end
            if (w_ready && w_gnt_valid && !w_rr_freeze) begin
                r_rr_ptr <= w_gnt_idx;
            end
            for (int i = 0; i < N_PORTS; i++) begin
                if (w_ready) begin
                    if (w_addr_gnt[i]) begin
                        r_pend[i] <= 1'b0;
                    end else if (w_live[i] && !r_pend[i]) begin
                        r_pend[i]      <= 1'b1;
                        r_haddr[i]     <= bus.ins_haddr[i*ADDR_W +: ADDR_W];
                        r_hwrite[i]    <= bus.ins_hwrite[i];
                        r_hsize[i]     <= bus.ins_hsize[i*3 +: 3];
                        r_hburst[i]    <= bus.ins_hburst[i*3 +: 3];
                        r_hprot[i]     <= bus.ins_hprot[i*4 +: 4];
                        r_htrans[i]    <= bus.ins_htrans[i*2 +: 2];
                        r_hmastlock[i] <= bus.ins_hmastlock[i];
                    end
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hasti_slave_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_hasti_slave_mux_rr
// Brief    : Directed bench for hasti_slave_mux_rr with an address/data
//            scoreboard and a small slave model (rdata = addr ^ 0xDEADBFEF).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hasti_slave_mux_rr;
    localparam int c_N = 3;
    localparam int c_AW = 32;
    localparam int c_DW = 32;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic        resp;
    } xfer_t;

    logic clk;
    logic reset;
    logic sl_ready;
    logic sl_resp;
    logic mon_en;
    logic [31:0] sl_addr;
    int n_checks;
    int n_fail;
    xfer_t exp_addr_q[$];
    xfer_t exp_data_q[$];

    hasti_slave_mux_rr_if #(.N_PORTS(c_N), .ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

    hasti_slave_mux_rr #(.N_PORTS(c_N), .ADDR_W(c_AW), .DATA_W(c_DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream slave: returns data derived from the accepted address.
    always @(posedge clk) begin
        if (reset) sl_addr <= '0;
        else if (bus.out_hsel && bus.out_hreadyout) sl_addr <= bus.out_haddr;
    end
    assign bus.out_hrdata    = sl_addr ^ 32'hDEADBFEF;
    assign bus.out_hreadyout = sl_ready;
    assign bus.out_hresp     = sl_resp;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        bus.ins_hsel      = '0;
        bus.ins_hreadyin  = '1;
        bus.ins_htrans    = '0;
        bus.ins_haddr     = '0;
        bus.ins_hwrite    = '0;
        bus.ins_hmastlock = '0;
        bus.ins_hsize     = '0;
        bus.ins_hburst    = '0;
        bus.ins_hprot     = '0;
    endtask

    task automatic drive(input int p, input logic [31:0] a, input logic w, input logic lk);
        bus.ins_hsel[p]          = 1'b1;
        bus.ins_hreadyin[p]      = 1'b1;
        bus.ins_htrans[p*2 +: 2] = 2'b10;
        bus.ins_haddr[p*32 +: 32] = a;
        bus.ins_hwrite[p]        = w;
        bus.ins_hmastlock[p]     = lk;
        bus.ins_hsize[p*3 +: 3]  = 3'b010;
    endtask

    task automatic push_x(input int p, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic r);
        xfer_t x;
        x.port = p; x.addr = a; x.write = w; x.data = d; x.resp = r;
        exp_addr_q.push_back(x);
        exp_data_q.push_back(x);
    endtask

    // Monitor: address phase on out_* when accepted, data phase one accepted slot later.
    initial begin : monitor
        logic  in_data;
        xfer_t e;
        logic [95:0] v;
        in_data = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                in_data = 1'b0;
            end else begin
                if (in_data && bus.out_hreadyout) begin
                    in_data = 1'b0;
                    if (exp_data_q.size() == 0) begin
                        chk("data_unexpected", 96'd1, 96'd0);
                    end else begin
                        e = exp_data_q.pop_front();
                        if (e.write) begin
                            chk("data_hwdata", {64'd0, bus.out_hwdata}, {64'd0, e.data});
                        end else begin
                            v = '0;
                            v[e.port*32 +: 32] = e.data;
                            chk("data_hrdata", bus.ins_hrdata, v);
                        end
                        v = '0;
                        v[e.port] = e.resp;
                        chk("data_hresp", {93'd0, bus.ins_hresp}, v);
                    end
                end
                if (bus.out_hsel && bus.out_hreadyout) begin
                    in_data = 1'b1;
                    if (exp_addr_q.size() == 0) begin
                        chk("addr_unexpected", 96'd1, 96'd0);
                    end else begin
                        e = exp_addr_q.pop_front();
                        chk("addr_phase", {61'd0, bus.out_htrans, bus.out_hwrite, bus.out_haddr},
                            {61'd0, 2'b10, e.write, e.addr});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        n_checks = 0; n_fail = 0;
        reset = 1'b1; mon_en = 1'b1; sl_ready = 1'b1; sl_resp = 1'b1;
        idle_ports();
        bus.ins_hwdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", {93'd0, bus.ins_hreadyout}, 96'h7);
        chk("rst_hresp", {93'd0, bus.ins_hresp}, 96'h0);
        chk("rst_hrdata", bus.ins_hrdata, 96'h0);
        chk("rst_hsel", {95'd0, bus.out_hsel}, 96'h0);
        step(); sl_ready = 1'b0;
        @(negedge clk);
        chk("rst_hreadyout_follow", {93'd0, bus.ins_hreadyout}, 96'h0);
        step(); sl_ready = 1'b1; sl_resp = 1'b0; reset = 1'b0;
        repeat (2) step();

        // Three-way contention from reset pointer: grants 0,1,2
        drive(0, 32'h100, 1'b0, 1'b0); drive(1, 32'h200, 1'b0, 1'b0); drive(2, 32'h300, 1'b0, 1'b0);
        push_x(0, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0);
        push_x(1, 32'h200, 1'b0, 32'hDEADBDEF, 1'b0);
        push_x(2, 32'h300, 1'b0, 32'hDEADBCEF, 1'b0);
        @(negedge clk); chk("cont_rdy_c0", {93'd0, bus.ins_hreadyout}, 96'h7);
        step(); idle_ports();
        @(negedge clk); chk("cont_rdy_c1", {93'd0, bus.ins_hreadyout}, 96'h1);
        step();
        @(negedge clk); chk("cont_rdy_c2", {93'd0, bus.ins_hreadyout}, 96'h3);
        step();
        @(negedge clk); chk("cont_rdy_c3", {93'd0, bus.ins_hreadyout}, 96'h7);
        repeat (3) step();

        // Single uncontended read on port 1, zero-cycle pass-through
        drive(1, 32'h100, 1'b0, 1'b0);
        push_x(1, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0);
        @(negedge clk); chk("single_hsel", {95'd0, bus.out_hsel}, 96'h1);
        step(); idle_ports();
        repeat (3) step();

        // Slave stall with port 1 captured
        drive(0, 32'h400, 1'b0, 1'b0); drive(1, 32'h500, 1'b0, 1'b0);
        push_x(0, 32'h400, 1'b0, 32'hDEADBBEF, 1'b0);
        push_x(1, 32'h500, 1'b0, 32'hDEADBAEF, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(); idle_ports(); sl_ready = 1'b0;
            @(negedge clk);
            chk("stall_haddr", {64'd0, bus.out_haddr}, 96'h500);
            chk("stall_hsel", {95'd0, bus.out_hsel}, 96'h1);
            chk("stall_hreadyout", {93'd0, bus.ins_hreadyout}, 96'h0);
        end
        step(); sl_ready = 1'b1;
        @(negedge clk); chk("stall_release_rdy", {93'd0, bus.ins_hreadyout}, 96'h5);
        repeat (3) step();

        // Error response during port 0 data phase
        drive(0, 32'h600, 1'b0, 1'b0);
        push_x(0, 32'h600, 1'b0, 32'hDEADB9EF, 1'b1);
        step(); idle_ports(); sl_resp = 1'b1;
        step(); sl_resp = 1'b0;
        repeat (3) step();

        // Fairness: port 2 just served, port 0 joins and wins the next slot
        drive(2, 32'h700, 1'b0, 1'b0);
        push_x(2, 32'h700, 1'b0, 32'hDEADB8EF, 1'b0);
        step();
        drive(2, 32'h704, 1'b0, 1'b0); drive(0, 32'h800, 1'b0, 1'b0);
        push_x(0, 32'h800, 1'b0, 32'hDEADB7EF, 1'b0);
        push_x(2, 32'h704, 1'b0, 32'hDEADB8EB, 1'b0);
        step(); idle_ports();
        repeat (3) step();

        // Contended writes: write data follows the data-phase owner
        drive(0, 32'h900, 1'b1, 1'b0); drive(1, 32'hA00, 1'b1, 1'b0);
        bus.ins_hwdata[0 +: 32]  = 32'h11111111;
        bus.ins_hwdata[32 +: 32] = 32'h22222222;
        push_x(0, 32'h900, 1'b1, 32'h11111111, 1'b0);
        push_x(1, 32'hA00, 1'b1, 32'h22222222, 1'b0);
        step(); idle_ports();
        repeat (3) step();
        bus.ins_hwdata = '0;
        step();

        // Reset in the middle of a contended burst
        mon_en = 1'b0;
        drive(0, 32'hD00, 1'b0, 1'b0); drive(1, 32'hD10, 1'b0, 1'b0); drive(2, 32'hD20, 1'b0, 1'b0);
        step(); idle_ports(); reset = 1'b1;
        step(); reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_hreadyout", {93'd0, bus.ins_hreadyout}, 96'h7);
        chk("rst_mid_hsel", {95'd0, bus.out_hsel}, 96'h0);
        chk("rst_mid_hrdata", bus.ins_hrdata, 96'h0);
        step(); mon_en = 1'b1;
        repeat (2) step();

`ifdef HASTI_MUX_LOCK_EN
        // Locked sequence on port 1 keeps port 0 waiting until the lock drops
        bus.ins_hwdata[32 +: 32] = 32'h33333333;
        drive(1, 32'hB00, 1'b1, 1'b1);
        push_x(1, 32'hB00, 1'b1, 32'h33333333, 1'b0);
        step();
        drive(1, 32'hB04, 1'b1, 1'b1); drive(0, 32'hC00, 1'b0, 1'b0);
        push_x(1, 32'hB04, 1'b1, 32'h33333333, 1'b0);
        step(); idle_ports();
        drive(1, 32'hB08, 1'b1, 1'b0);
        push_x(1, 32'hB08, 1'b1, 32'h33333333, 1'b0);
        push_x(0, 32'hC00, 1'b0, 32'hDEADB3EF, 1'b0);
        step(); idle_ports();
        repeat (4) step();
        bus.ins_hwdata = '0;
`endif

        repeat (5) step();
        chk("addr_q_drained", 96'(exp_addr_q.size()), 96'd0);
        chk("data_q_drained", 96'(exp_data_q.size()), 96'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
